object_buffer_reader: RTL and testbench

//  Drain side of the object buffer. Pops BUFFER_ENTRY rows in order and emits the protobuf header per entry:
//  key varint, plus a length varint for LEN wire types. Then hands the payload phase to the serializer and waits for completion.

---
 rtl/object_buffer_reader.sv | 181 ++++++++++++++++++
 tb/tb_object_buffer_reader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_buffer_reader.sv
// Object buffer drain: pops entries, emits protobuf key/length varint headers, then runs the payload handshake.
// Optional macro OBJECT_BUFFER_READER_SKIP_EMPTY_EN drops empty non-nested LEN entries (proto3 default omission).
module object_buffer_reader #(
  parameter int FID_W  = 29,
  parameter int SIZE_W = 16,
  parameter int PTR_W  = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           buf_empty,
  input  logic [FID_W+SIZE_W+PTR_W+6:0]  buf_entry,
  output logic                           buf_rd_en,
  output logic                           out_valid,
  output logic [7:0]                     out_data,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic                           pay_req,
  output logic [4:0]                     pay_type,
  output logic [SIZE_W-1:0]              pay_size,
  input  logic                           pay_done,
  output logic                           nest_push,
  output logic [PTR_W-1:0]               nest_ptr,
  output logic                           err,
  output logic [1:0]                     dbg_state
);

  localparam int KEY_W = FID_W + 3;

  typedef enum logic [1:0] {IDLE, KEY, LEN, PAY} state_t;

  state_t              state, state_n;
  logic [KEY_W-1:0]    sh;
  logic [2:0]          wire_q;
  logic [4:0]          type_q;
  logic [SIZE_W-1:0]   size_q;
  logic                nested_q;
  logic [PTR_W-1:0]    ptr_q;

  logic                e_valid, e_nested, e_legal, e_skip, e_accept;
  logic [FID_W-1:0]    e_fid;
  logic [4:0]          e_type;
  logic [SIZE_W-1:0]   e_size;
  logic [PTR_W-1:0]    e_ptr;
  logic [2:0]          e_wire;
  logic                sh_more, err_set;
  logic                load_key, load_len, shift, enter_pay;

  function automatic logic [2:0] wire_type(input logic [4:0] t);
    case (t)
      5'd1, 5'd6, 5'd16:  wire_type = 3'd1;
      5'd2, 5'd7, 5'd15:  wire_type = 3'd5;
      5'd9, 5'd11, 5'd12: wire_type = 3'd2;
      5'd10:              wire_type = 3'd3;
      default:            wire_type = 3'd0;
    endcase
  endfunction

  // Entry layout, MSB first: {valid, field_id, field_type, size, nested, nested_type_table}
  assign e_valid  = buf_entry[FID_W+SIZE_W+PTR_W+6];
  assign e_fid    = buf_entry[PTR_W+SIZE_W+6 +: FID_W];
  assign e_type   = buf_entry[PTR_W+SIZE_W+1 +: 5];
  assign e_size   = buf_entry[PTR_W+1 +: SIZE_W];
  assign e_nested = buf_entry[PTR_W];
  assign e_ptr    = buf_entry[PTR_W-1:0];
  assign e_wire   = wire_type(e_type);
  assign e_legal  = (e_type != 5'd0) && (e_type <= 5'd18);

`ifdef OBJECT_BUFFER_READER_SKIP_EMPTY_EN
  assign e_skip = (e_wire == 3'd2) && !e_nested && (e_size == '0);
`else
  assign e_skip = 1'b0;
`endif

  assign e_accept = e_valid && e_legal && !e_skip;

  // The shift register holds the unsent varint groups; more groups remain while any bit above 6 is set.
  assign sh_more = |sh[KEY_W-1:7];

  // Handshake: a header byte transfers on a cycle where out_valid && out_ready; while out_valid is
  // high and out_ready low, out_data/out_last/out_valid hold. Once raised, out_valid stays high until
  // the byte transfers.
  always_comb begin
    state_n   = state;
    buf_rd_en = 1'b0;
    out_valid = 1'b0;
    load_key  = 1'b0;
    load_len  = 1'b0;
    shift     = 1'b0;
    enter_pay = 1'b0;
    case (state)
      IDLE: begin
        if (!buf_empty) begin
          buf_rd_en = 1'b1;
          if (e_accept) begin
            state_n  = KEY;
            load_key = 1'b1;
          end
        end
      end
      KEY: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (sh_more) begin
            shift = 1'b1;
          end else if (wire_q == 3'd2) begin
            state_n  = LEN;
            load_len = 1'b1;
          end else begin
            state_n   = PAY;
            enter_pay = 1'b1;
          end
        end
      end
      LEN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (sh_more) begin
            shift = 1'b1;
          end else begin
            state_n   = PAY;
            enter_pay = 1'b1;
          end
        end
      end
      PAY: begin
        // The return to IDLE may coincide with the next pop so entries issue back-to-back.
        if (pay_done) begin
          state_n = IDLE;
          if (!buf_empty) begin
            buf_rd_en = 1'b1;
            if (e_accept) begin
              state_n  = KEY;
              load_key = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_data  = out_valid ? {sh_more, sh[6:0]} : 8'h00;
  assign out_last  = out_valid && !sh_more && ((state == LEN) || (wire_q != 3'd2));
  assign pay_req   = (state == PAY);
  assign pay_type  = type_q;
  assign pay_size  = size_q;
  assign nest_ptr  = nest_push ? ptr_q : '0;
  assign err_set   = buf_rd_en && e_valid && !e_legal;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sh        <= '0;
      wire_q    <= '0;
      type_q    <= '0;
      size_q    <= '0;
      nested_q  <= 1'b0;
      ptr_q     <= '0;
      nest_push <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      nest_push <= enter_pay && nested_q;
      err       <= err || err_set;
      if (load_key) begin
        sh       <= {e_fid, e_wire};
        wire_q   <= e_wire;
        type_q   <= e_type;
        size_q   <= e_size;
        nested_q <= e_nested;
        ptr_q    <= e_ptr;
      end else if (load_len) begin
        sh <= {{(KEY_W-SIZE_W){1'b0}}, size_q};
      end else if (shift) begin
        sh <= sh >> 7;
      end
    end
  end

endmodule

// File: tb/tb_object_buffer_reader.sv
// Bench for object_buffer_reader: directed header cases plus randomized entries against a varint reference model.
// Honours OBJECT_BUFFER_READER_SKIP_EMPTY_EN the same way the design does.
module tb_object_buffer_reader;

  localparam int FID_W   = 29;
  localparam int SIZE_W  = 16;
  localparam int PTR_W   = 64;
  localparam int ENTRY_W = 1 + FID_W + 5 + SIZE_W + 1 + PTR_W;

  logic                clk;
  logic                reset_n;
  logic                buf_empty;
  logic [ENTRY_W-1:0]  buf_entry;
  logic                buf_rd_en;
  logic                out_valid;
  logic [7:0]          out_data;
  logic                out_last;
  logic                out_ready;
  logic                pay_req;
  logic [4:0]          pay_type;
  logic [SIZE_W-1:0]   pay_size;
  logic                pay_done;
  logic                nest_push;
  logic [PTR_W-1:0]    nest_ptr;
  logic                err;
  logic [1:0]          dbg_state;

  object_buffer_reader #(.FID_W(FID_W), .SIZE_W(SIZE_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset_n(reset_n), .buf_empty(buf_empty), .buf_entry(buf_entry),
    .buf_rd_en(buf_rd_en), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .pay_req(pay_req), .pay_type(pay_type), .pay_size(pay_size),
    .pay_done(pay_done), .nest_push(nest_push), .nest_ptr(nest_ptr), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;

  logic [ENTRY_W-1:0]  bq[$];        // object buffer contents, head = bq[0]
  logic [8:0]          exp_q[$];     // {last, byte}
  logic [SIZE_W+4:0]   pay_q[$];     // {type, size}
  logic [PTR_W:0]      nest_q[$];    // {nested, ptr}
  logic [7:0]          got_q[$];     // bytes seen on the header port
  bit                  exp_err;
  bit                  in_flight;
  int                  ready_mode;
  int                  pat_idx;
  int                  pay_wait;
  int                  pay_delay;
  logic                prev_valid, prev_ready, prev_pay_req, prev_pay_done;
  logic [8:0]          prev_byte;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] wire_of(input logic [4:0] t);
    case (t)
      5'd1, 5'd6, 5'd16:  return 3'd1;
      5'd2, 5'd7, 5'd15:  return 3'd5;
      5'd9, 5'd11, 5'd12: return 3'd2;
      5'd10:              return 3'd3;
      default:            return 3'd0;
    endcase
  endfunction

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic v, input logic [FID_W-1:0] fid,
      input logic [4:0] t, input logic [SIZE_W-1:0] s, input logic n, input logic [PTR_W-1:0] p);
    return {v, fid, t, s, n, p};
  endfunction

  task automatic push_varint(input longint unsigned v, input bit is_final);
    longint unsigned r;
    longint unsigned g;
    r = v;
    do begin
      g = r % 128;
      r = r / 128;
      exp_q.push_back({(is_final && r == 0), (r != 0), g[6:0]});
    end while (r != 0);
  endtask

  task automatic model_pop(input logic [ENTRY_W-1:0] e);
    logic v, n;
    logic [FID_W-1:0] fid;
    logic [4:0] t;
    logic [SIZE_W-1:0] s;
    logic [PTR_W-1:0] p;
    logic [2:0] w;
    {v, fid, t, s, n, p} = e;
    if (!v) return;
    if (t == 0 || t > 18) begin
      exp_err = 1'b1;
      return;
    end
    w = wire_of(t);
`ifdef OBJECT_BUFFER_READER_SKIP_EMPTY_EN
    if (w == 3'd2 && !n && s == 0) return;
`endif
    in_flight = 1'b1;
    push_varint(longint'(fid) * 8 + longint'(w), w != 3'd2);
    if (w == 3'd2) push_varint(longint'(s), 1'b1);
    pay_q.push_back({t, s});
    nest_q.push_back({n, p});
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    bit exp_rd, rise;
    logic [PTR_W:0] nq;
    nq = '0;
    check("err", err, exp_err);
    exp_rd = !buf_empty && (!in_flight || (pay_req && pay_done));
    check("buf_rd_en", buf_rd_en, exp_rd);
    if (prev_valid && !prev_ready)
      check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_byte});
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (exp_q.size() == 0) check("extra_byte", 1, 0);
      else check("hdr_byte", {out_last, out_data}, exp_q.pop_front());
    end
    if (prev_pay_req && !pay_req) check("pay_req_hold", prev_pay_done, 1);
    rise = pay_req && !prev_pay_req;
    if (rise) begin
      check("hdr_before_pay", exp_q.size(), 0);
      if (pay_q.size() == 0) begin
        check("spurious_pay", 1, 0);
      end else begin
        check("pay_type_size", {pay_type, pay_size}, pay_q.pop_front());
        nq = nest_q.pop_front();
      end
    end
    check("nest_push", nest_push, rise && nq[PTR_W]);
    if (nest_push) check("nest_ptr", nest_ptr, nq[PTR_W-1:0]);
    if (pay_req && pay_done) in_flight = 1'b0;
    if (buf_rd_en && bq.size() > 0) model_pop(bq.pop_front());
    prev_valid    = out_valid;
    prev_ready    = out_ready;
    prev_byte     = {out_last, out_data};
    prev_pay_req  = pay_req;
    prev_pay_done = pay_done;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [127:0] g;
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge clk);
    g = {$urandom, $urandom, $urandom, $urandom};
    buf_empty = (bq.size() == 0);
    buf_entry = buf_empty ? g[ENTRY_W-1:0] : bq[0];
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin out_ready = pat[3 - (pat_idx % 4)]; pat_idx++; end
      default: out_ready = 1'b0;
    endcase
    if (pay_req) begin
      pay_done = (pay_wait >= pay_delay);
      pay_wait++;
    end else begin
      pay_wait  = 0;
      pay_delay = $urandom_range(0, 3);
      pay_done  = ($urandom_range(0, 7) == 0);
    end
    #1;
    monitor();
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bq.size() == 0 && exp_q.size() == 0 && pay_q.size() == 0 && !in_flight) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_done", done, 1);
  endtask

  task automatic run_entry(input logic [ENTRY_W-1:0] e, input int mode);
    ready_mode = mode;
    pat_idx    = 0;
    got_q.delete();
    bq.push_back(e);
    drain(200);
    step();
  endtask

  task automatic check_bytes(input string tag, input logic [39:0] exp, input int n);
    logic [8:0] gb;
    check({tag, "_len"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      gb = (i < got_q.size()) ? {1'b0, got_q[i]} : 9'h100;
      check(tag, gb, {1'b0, exp[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {buf_rd_en, out_valid, out_data, out_last, pay_req, pay_type, pay_size,
                nest_push, nest_ptr, err}, 0);
  endtask

  function automatic logic [ENTRY_W-1:0] rand_entry();
    logic v, n;
    logic [FID_W-1:0] fid;
    logic [4:0] t;
    logic [SIZE_W-1:0] s;
    v = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 9) == 0) t = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(19, 31));
    else t = 5'($urandom_range(1, 18));
    case ($urandom_range(0, 3))
      0: fid = FID_W'($urandom_range(0, 15));
      1: fid = '1;
      default: fid = FID_W'($urandom);
    endcase
    case ($urandom_range(0, 7))
      0: s = 16'd0;
      1: s = 16'd127;
      2: s = 16'd128;
      3: s = 16'd16383;
      4: s = 16'd16384;
      5: s = 16'hFFFF;
      default: s = 16'($urandom_range(0, 65535));
    endcase
    n = ($urandom_range(0, 3) == 0);
    return mk_entry(v, fid, t, s, n, {$urandom, $urandom});
  endfunction

  task automatic clear_model();
    exp_q.delete();
    pay_q.delete();
    nest_q.delete();
    in_flight     = 1'b0;
    exp_err       = 1'b0;
    prev_valid    = 1'b0;
    prev_ready    = 1'b0;
    prev_byte     = '0;
    prev_pay_req  = 1'b0;
    prev_pay_done = 1'b0;
    pay_wait      = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; buf_empty = 1'b1; buf_entry = '0; out_ready = 1'b0; pay_done = 1'b0;
    ready_mode = 0; pat_idx = 0; pay_delay = 0;
    clear_model();
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;

    run_entry(mk_entry(1'b1, 29'd1, 5'd5, 16'd0, 1'b0, 64'd0), 0);
    check_bytes("int32_key", 40'h08, 1);

    run_entry(mk_entry(1'b1, 29'd2, 5'd9, 16'd300, 1'b0, 64'd0), 0);
    check_bytes("len300", 40'h12AC02, 3);

    run_entry(mk_entry(1'b1, 29'h1FFFFFFF, 5'd6, 16'd0, 1'b0, 64'd0), 0);
    check_bytes("max_fid", 40'hF9FFFFFF0F, 5);

    run_entry(mk_entry(1'b1, 29'd3, 5'd11, 16'd5, 1'b1, 64'hDEAD_BEEF), 0);
    check_bytes("nested", 40'h1A05, 2);

    run_entry(mk_entry(1'b1, 29'd2, 5'd9, 16'd300, 1'b0, 64'd0), 2);
    check_bytes("len300_bp", 40'h12AC02, 3);

    run_entry(mk_entry(1'b1, 29'd4, 5'd0, 16'd7, 1'b0, 64'd0), 0);
    check_bytes("bad_type", 40'h0, 0);
    check("bad_type_err", err, 1);
    run_entry(mk_entry(1'b1, 29'd1, 5'd5, 16'd0, 1'b0, 64'd0), 0);
    check_bytes("after_err", 40'h08, 1);

    run_entry(mk_entry(1'b1, 29'd1, 5'd9, 16'd0, 1'b0, 64'd0), 0);
`ifdef OBJECT_BUFFER_READER_SKIP_EMPTY_EN
    check_bytes("empty_len", 40'h0, 0);
`else
    check_bytes("empty_len", 40'h0A00, 2);
`endif

    run_entry(mk_entry(1'b0, 29'd5, 5'd5, 16'd0, 1'b0, 64'd0), 0);
    check_bytes("invalid_entry", 40'h0, 0);

    // Reset while the length varint is being sent.
    ready_mode = 1;
    bq.push_back(mk_entry(1'b1, 29'd2, 5'd9, 16'd300, 1'b1, 64'h1234));
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 2 && in_flight) break;
      step();
    end
    check("reached_len", exp_q.size(), 2);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("reset_mid_len");
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 1;
    got_q.delete();
    repeat (6) step();
    check_bytes("no_replay", 40'h0, 0);
    run_entry(mk_entry(1'b1, 29'd7, 5'd1, 16'd0, 1'b0, 64'd0), 1);
    check_bytes("post_reset", 40'h39, 1);

    // Randomized traffic.
    ready_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (bq.size() < 3 && $urandom_range(0, 3) == 0) bq.push_back(rand_entry());
      step();
    end
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
